// File: rtl/cache_pkg.sv
// cache_pkg: shared line/beat/address widths and the burst adapter state encoding.
package cache_pkg;
    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int ADDR_W = 32;
    typedef logic [LINE_W-1:0] line_t;
    typedef logic [BEAT_W-1:0] beat_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} adapter_state_t;
endpackage

// File: rtl/cacheline_burst_adapter.sv
// cacheline_burst_adapter: turns whole-line cache fills/writebacks into fixed-length memory bursts.
module cacheline_burst_adapter #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] address_i,
    input  logic [LINE_W-1:0] line_i,
    output logic [LINE_W-1:0] line_o,
    output logic              resp_o,
    output logic [ADDR_W-1:0] address_o,
    output logic              read_o,
    output logic              write_o,
    output logic [BEAT_W-1:0] burst_o,
    input  logic [BEAT_W-1:0] burst_i,
    input  logic              resp_i
);
    import cache_pkg::*;
    localparam int BEATS = LINE_W / BEAT_W;
    localparam int OFS_W = $clog2(LINE_W / 8);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    adapter_state_t state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wr_line, rd_line, rd_next;
    logic in_burst, last_beat;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    assign in_burst = (state == RD_BURST) || (state == WR_BURST);
    assign last_beat = in_burst && resp_i && (cnt == CNT_W'(BEATS - 1));
    always_comb begin
        state_n = (state == IDLE) ? (write_i ? WR_BURST : read_i ? RD_BURST : IDLE) :
                  (state == DONE) ? IDLE : last_beat ? DONE : state;
        read_o = state == RD_BURST;
        write_o = state == WR_BURST;
        resp_o = state == DONE;
        address_o = in_burst ? addr_q : '0;
        burst_o = write_o ? wr_line[cnt*BEAT_W +: BEAT_W] : '0;
        rd_next = rd_line;
        rd_next[cnt*BEAT_W +: BEAT_W] = burst_i;
    end
    // Fill data is assembled off to the side so line_o only changes once a fill completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            addr_q <= '0;
            wr_line <= '0;
            rd_line <= '0;
            line_o <= '0;
        end else begin
            if (state == IDLE && (write_i || read_i)) begin
                addr_q <= {address_i[ADDR_W-1:OFS_W], OFS_W'(0)};
                if (write_i) wr_line <= line_i;
            end
            if (in_burst && resp_i) begin
                cnt <= last_beat ? '0 : cnt + 1'b1;
                if (read_o) rd_line <= rd_next;
                if (read_o && last_beat) line_o <= rd_next;
            end
        end
    end
endmodule
